// File: rtl/gate_sweep_controller.sv
// Self-test sequencer for one combinational gate: walks every input vector,
// holds it for HOLD_CYCLES settle cycles, samples the output and tallies mismatches.
module gate_sweep_controller #(
    parameter int                         N_INPUTS    = 2,
    parameter int                         HOLD_CYCLES = 1,
    parameter logic [(1<<N_INPUTS)-1:0]   EXPECTED    = 4'b1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  gate_out,
    output logic [N_INPUTS-1:0]   gate_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_INPUTS:0]     fail_count,
    output logic [N_INPUTS-1:0]   first_fail_vec,
    output logic                  first_fail_valid
);

    localparam int                CW       = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]     HOLD_LD  = CW'(HOLD_CYCLES);
    localparam logic [N_INPUTS-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [N_INPUTS-1:0]   vec_q, vec_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_INPUTS:0]     fails_q, fails_d;
    logic [N_INPUTS-1:0]   ffv_q, ffv_d;
    logic                  ffvalid_q, ffvalid_d;
    logic                  mismatch;

    assign mismatch = (gate_out != EXPECTED[vec_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            fails_q   <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            fails_q   <= fails_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        fails_d   = fails_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;

        case (state_q)
            IDLE, DONE: begin
                // abort beats start: a simultaneous pair parks the sweeper in IDLE
                if (abort && start) begin
                    state_d = IDLE;
                    vec_d   = '0;
                end else if (start) begin
                    state_d   = SETTLE;
                    vec_d     = '0;
                    cnt_d     = HOLD_LD;
                    fails_d   = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                end else begin
                    if (mismatch) begin
                        fails_d = fails_q + (N_INPUTS + 1)'(1);
                        if (!ffvalid_q) begin
                            ffvalid_d = 1'b1;
                            ffv_d     = vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                    end else begin
                        state_d = SETTLE;
                        vec_d   = vec_q + N_INPUTS'(1);
                        cnt_d   = HOLD_LD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gate_in          = vec_q;
    assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done             = (state_q == DONE);
    assign pass             = done && (fails_q == '0);
    assign fail_count       = fails_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Scoreboard bench: two sweeper instances (2-input/hold 1 and 3-input/hold 3) driving
// modelled gates; expected summaries are queued at start and checked when done rises.
module tb_gate_sweep_controller;

    localparam logic [3:0] EXPA = 4'b1000;
    localparam logic [7:0] EXPB = 8'b10010110;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic [3:0] tt_a;
    logic [7:0] tt_b;
    logic       gout_a, gout_b;
    logic [1:0] gin_a;
    logic [2:0] gin_b;
    logic       busy_a, done_a, pass_a, ffvld_a;
    logic       busy_b, done_b, pass_b, ffvld_b;
    logic [2:0] fc_a;
    logic [3:0] fc_b;
    logic [1:0] ffv_a;
    logic [2:0] ffv_b;

    assign gout_a = tt_a[gin_a];
    assign gout_b = tt_b[gin_b];

    gate_sweep_controller #(.N_INPUTS(2), .HOLD_CYCLES(1), .EXPECTED(EXPA)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .gate_out(gout_a),
        .gate_in(gin_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_count(fc_a), .first_fail_vec(ffv_a), .first_fail_valid(ffvld_a)
    );

    gate_sweep_controller #(.N_INPUTS(3), .HOLD_CYCLES(3), .EXPECTED(EXPB)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .gate_out(gout_b),
        .gate_in(gin_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_count(fc_b), .first_fail_vec(ffv_b), .first_fail_valid(ffvld_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     inst;
        int     fc;
        int     ffv;
        int     ffvalid;
        int     pass_;
        longint dcyc;
    } exp_t;

    exp_t   exp_q[$];
    longint cyc = 0;
    longint e0 = 0;
    int     active = -1;
    int     checks = 0;
    int     failures = 0;
    logic   dprev_a = 1'b0, dprev_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nv(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int hd(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Tally over the first ncomp vectors: a vector fails when the gate disagrees with the table.
    function automatic exp_t model(input int i, input int ttv, input int ncomp, input longint st);
        exp_t r;
        int   ex;
        ex = (i == 0) ? int'(EXPA) : int'(EXPB);
        r.inst = i; r.fc = 0; r.ffv = 0; r.ffvalid = 0;
        for (int k = 0; k < ncomp; k++) begin
            if (((ttv >> k) & 1) != ((ex >> k) & 1)) begin
                r.fc++;
                if (r.ffvalid == 0) begin
                    r.ffvalid = 1;
                    r.ffv = k;
                end
            end
        end
        r.pass_ = (r.fc == 0) ? 1 : 0;
        r.dcyc  = st + longint'(nv(i) * (hd(i) + 1));
        return r;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic sample_outs(input int i, output int gi, output int bs, output int dn,
                               output int ps, output int fc, output int ffv, output int fv);
        if (i == 0) begin
            gi = int'(gin_a); bs = int'(busy_a); dn = int'(done_a); ps = int'(pass_a);
            fc = int'(fc_a); ffv = int'(ffv_a); fv = int'(ffvld_a);
        end else begin
            gi = int'(gin_b); bs = int'(busy_b); dn = int'(done_b); ps = int'(pass_b);
            fc = int'(fc_b); ffv = int'(ffv_b); fv = int'(ffvld_b);
        end
    endtask

    task automatic on_done(input int i);
        exp_t e;
        int gi, bs, dn, ps, fc, ffv, fv;
        sample_outs(i, gi, bs, dn, ps, fc, ffv, fv);
        if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("done_inst", i, e.inst);
            check("done_cycle", cyc, e.dcyc);
            check("fail_count", fc, e.fc);
            check("first_fail_valid", fv, e.ffvalid);
            if (e.ffvalid != 0) check("first_fail_vec", ffv, e.ffv);
            check("pass", ps, e.pass_);
            check("busy_at_done", bs, 0);
            check("gate_in_at_done", gi, nv(i) - 1);
            $display("sweep inst=%0d done@%0d fail_count=%0d first_fail=%0d/%0d pass=%0d",
                     i, cyc, fc, fv, ffv, ps);
        end
        if (active == i) active = -1;
    endtask

    // Monitor: checks the vector schedule every cycle and pops the scoreboard on done rising.
    initial begin : monitor
        longint d;
        int gi, bs, dn, ps, fc, ffv, fv;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done_a && !dprev_a) on_done(0);
                if (done_b && !dprev_b) on_done(1);
                if (active >= 0) begin
                    d = cyc - e0;
                    if (d >= 0 && d < longint'(nv(active) * (hd(active) + 1))) begin
                        sample_outs(active, gi, bs, dn, ps, fc, ffv, fv);
                        check("gate_in_sched", gi, d / longint'(hd(active) + 1));
                        check("busy_sched", bs, 1);
                    end
                end
            end
            dprev_a = done_a;
            dprev_b = done_b;
        end
    end

    task automatic run_start(input int i, input int ttv, output longint st);
        @(negedge clk);
        if (i == 0) begin
            tt_a = ttv[3:0]; start_a = 1'b1;
        end else begin
            tt_b = ttv[7:0]; start_b = 1'b1;
        end
        st = cyc + 1;
        exp_q.push_back(model(i, ttv, nv(i), st));
        e0 = st;
        active = i;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
            active = -1;
        end
        @(negedge clk);
    endtask

    task automatic sweep(input int i, input int ttv);
        longint st;
        run_start(i, ttv, st);
        wait_done(100);
    endtask

    task automatic abort_test(input int i, input int ttv);
        longint st;
        int     off, ncomp;
        exp_t   e;
        int gi, bs, dn, ps, fc, ffv, fv;
        run_start(i, ttv, st);
        off = $urandom_range(nv(i) * (hd(i) + 1) - 1, 1);
        repeat (off - 1) @(negedge clk);
        active = -1;
        void'(exp_q.pop_back());
        if (i == 0) abort_a = 1'b1; else abort_b = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        abort_b = 1'b0;
        // vectors whose sampling edge came strictly before the abort edge
        ncomp = (off - 1) / (hd(i) + 1);
        e = model(i, ttv, ncomp, st);
        sample_outs(i, gi, bs, dn, ps, fc, ffv, fv);
        check("abort_busy", bs, 0);
        check("abort_done", dn, 0);
        check("abort_gate_in", gi, 0);
        check("abort_fail_count", fc, e.fc);
        check("abort_ff_valid", fv, e.ffvalid);
        if (e.ffvalid != 0) check("abort_ff_vec", ffv, e.ffv);
        $display("abort inst=%0d off=%0d partial_fails=%0d", i, off, fc);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_gate_in"}, gin_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_pass"}, pass_a, 0);
        check({tag, "_fail_count"}, fc_a, 0);
        check({tag, "_ff_vec"}, ffv_a, 0);
        check({tag, "_ff_valid"}, ffvld_a, 0);
        check({tag, "_busy_b"}, busy_b, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        longint st;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        tt_a = 4'b1000; tt_b = 8'h00;
        #12;
        check_reset_a("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep(0, 4'b1000);           // real AND gate
        sweep(0, 4'b0000);           // output stuck at 0
        sweep(0, 4'b0111);           // NAND against AND table
        for (int n = 0; n < 6; n++) sweep(0, int'($urandom_range(15, 0)));

        abort_test(0, int'($urandom_range(15, 0)));
        sweep(0, 4'b1000);
        for (int n = 0; n < 3; n++) abort_test(0, int'($urandom_range(15, 0)));

        // abort and start together in IDLE: stay idle
        @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        check("start_abort_busy", busy_a, 0);
        check("start_abort_done", done_a, 0);
        @(negedge clk);
        check("start_abort_idle_busy", busy_a, 0);

        // asynchronous reset while vector 2 is on the gate
        run_start(0, 4'b1000, st);
        repeat (4) @(negedge clk);
        check("pre_reset_gate_in", gin_a, 2);
        active = -1;
        void'(exp_q.pop_back());
        #2 rst_n = 1'b0;
        #1 check_reset_a("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, 4'b1000);

        // XOR3 on the 3-input, hold-3 sweeper, with a start re-pulse while busy
        run_start(1, 8'b10010110, st);
        repeat (4) @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(100);
        for (int n = 0; n < 4; n++) sweep(1, int'($urandom_range(255, 0)));
        abort_test(1, int'($urandom_range(255, 0)));
        sweep(1, 8'b10010110);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_sweep_controller.md
# gate_sweep_controller

Sequencer that exhaustively exercises one combinational gate instance in hardware. On `start` it steps the gate inputs through every combination from 0 to 2^N_INPUTS-1, holding each vector for a settle interval and sampling the gate output. It compares each sample against a parameterised expected truth table and reports a pass/fail summary. It sits beside any gate in the library (and, or, xor, nand, …) as its self-test driver, replacing the hand-written stimulus of a simulation bench with synthesizable sequencing.

## Interface
- `N_INPUTS`, default 2: number of gate inputs; legal range 1–4.
- `HOLD_CYCLES`, default 1: settle cycles per vector before sampling; must be ≥1.
- `EXPECTED`, default 4'b1000 (AND): 2^N_INPUTS-bit truth table; bit k is the expected output for input vector k.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a sweep; sampled only in IDLE or DONE.
- `abort`  input  1  synchronous abandon of a sweep in progress.
- `gate_out`  input  1  output of the gate under control (`y`).
- `gate_in`  output  N_INPUTS  drives gate inputs; bit N_INPUTS-1 is MSB (`a` for N=2), bit 0 is LSB (`b`).
- `busy`  output  1  high in SETTLE or SAMPLE.
- `done`  output  1  high in DONE; sticky until the next start, abort or reset.
- `pass`  output  1  `done` && `fail_count`==0.
- `fail_count`  output  N_INPUTS+1  number of mismatching vectors in the current or last sweep.
- `first_fail_vec`  output  N_INPUTS  lowest-index mismatching vector; valid when `first_fail_valid`.
- `first_fail_valid`  output  1  at least one mismatch recorded.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Reset state is IDLE.
- IDLE or DONE with `start`=1 (and `abort`=0):
  - Go to SETTLE.
  - `gate_in`←0, settle counter←HOLD_CYCLES.
  - Clear `fail_count` and `first_fail_valid`; `first_fail_vec`←0.
- SETTLE: decrement the settle counter each cycle. When the counter reaches 1, go to SAMPLE; SETTLE therefore lasts exactly HOLD_CYCLES cycles.
- SAMPLE (one cycle):
  - Compare `gate_out` with `EXPECTED[gate_in]`.
  - On mismatch: `fail_count`++; if `first_fail_valid`=0, set `first_fail_valid` and latch `first_fail_vec`←`gate_in`.
  - If `gate_in`==2^N_INPUTS-1, go to DONE and hold `gate_in`.
  - Otherwise `gate_in`++, reload the settle counter, and go to SETTLE.
- `gate_in` changes only on SETTLE entry. It is stable throughout SETTLE and SAMPLE of each vector.
- DONE: hold all results. `start` re-arms a new sweep; other inputs are ignored.
- `abort`=1 in SETTLE or SAMPLE:
  - Go to IDLE next cycle and set `gate_in`←0.
  - `done` is not asserted.
  - `fail_count`, `first_fail_*` keep their partial values until the next start.
- `abort` in IDLE/DONE: no effect. `abort` and `start` together: `abort` wins, go to or stay in IDLE.
- `start` while `busy`: ignored; the sweep continues unchanged.
- `fail_count` cannot overflow: its width holds the value 2^N_INPUTS.

## Timing
- Reset values (async, immediate on `rst_n`=0):
  - `gate_in`=0, `busy`=0, `done`=0, `pass`=0.
  - `fail_count`=0, `first_fail_vec`=0, `first_fail_valid`=0.
- Reset mid-sweep returns all outputs to reset values at once. Release is sampled synchronously, with the first active edge after deassertion.
- `start` sampled at edge E0: `busy`=1 from E0. Vector k is driven from edge E0+k·(HOLD_CYCLES+1).
- `gate_out` is sampled at the edge ending SAMPLE, i.e. edge E0+(k+1)·(HOLD_CYCLES+1).
- `done` rises at edge E0+2^N_INPUTS·(HOLD_CYCLES+1). For defaults this is E0+8; `busy` falls at the same edge.
- `pass`, `fail_count`, `first_fail_*` are registered and are final when `done` rises.
- `gate_out` is treated as combinational from `gate_in`. The settle interval covers the gate's propagation delay.

## Test plan
- Defaults with a real AND gate; pulse `start` → vectors 0,1,2,3 each held 2 cycles; `done` at +8 cycles; `pass`=1, `fail_count`=0, `first_fail_valid`=0.
- AND `EXPECTED` with `gate_out` tied to 0 → `fail_count`=1, `first_fail_vec`=3, `pass`=0.
- AND `EXPECTED` driving a NAND gate → `fail_count`=4, `first_fail_vec`=0, `first_fail_valid`=1.
- `HOLD_CYCLES`=3, N_INPUTS=3, XOR3 gate with `EXPECTED`=8'b10010110 → each vector held 4 cycles; `done` at +32 cycles; `pass`=1. Re-pulse `start` at cycle 5 → no effect on timing.
- `abort` at cycle 3 of a default sweep → IDLE next cycle, `gate_in`=0, `done`=0. A new `start` then completes normally with `pass`=1.
- `rst_n` low mid-sweep (vector 2), between clock edges → all outputs at reset values immediately. After release, `start` runs a full sweep from vector 0.
